// File: rtl/gtxe2_oob_pkg.sv
// Shared OOB definitions for the GTXE2 channel TX generator and RX detector.
// Window limits live here so both ends of the link agree on legal timing.
package gtxe2_oob_pkg;

  typedef enum logic [1:0] {StReady, StBurst, StGap, StFinish} oob_state_e;

  typedef enum logic [1:0] {LineIdle, LineBurst, LineData} line_mode_e;

  localparam int unsigned DefBurstLen   = 240;
  localparam int unsigned DefWakeGapLen = 240;
  localparam int unsigned DefInitGapLen = 720;
  localparam int unsigned DefBurstsNum  = 6;

  localparam int unsigned BurstWinMin = 150;
  localparam int unsigned BurstWinMax = 340;
  localparam int unsigned InitWinMin  = 450;
  localparam int unsigned InitWinMax  = 990;

  localparam int unsigned SataBurstVal = 4;

  function automatic bit in_window(int unsigned v, int unsigned lo, int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_line.sv
// Registered TXP/TXN line encoder: idle, alternating burst pattern, or serial data.
module gtxe2_chnl_tx_oob_line
  import gtxe2_oob_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  line_mode_e mode,
  input  logic       txdata,
  output logic       txp,
  output logic       txn
);

  // Holds the last burst value; cleared outside bursts so each burst starts at 1.
  logic tog_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      txp   <= 1'b0;
      txn   <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      case (mode)
        LineBurst: begin
          txp   <= ~tog_q;
          txn   <= tog_q;
          tog_q <= ~tog_q;
        end
        LineData: begin
          txp   <= txdata;
          txn   <= ~txdata;
          tog_q <= 1'b0;
        end
        default: begin
          txp   <= 1'b0;
          txn   <= 1'b0;
          tog_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gtxe2_chnl_tx_oob.sv
// GTXE2 TX OOB generator: emits COMINIT/COMWAKE burst/gap sequences, otherwise
// passes serial data or holds electrical idle.
module gtxe2_chnl_tx_oob
  import gtxe2_oob_pkg::*;
#(
  parameter int unsigned burst_len    = DefBurstLen,
  parameter int unsigned wake_gap_len = DefWakeGapLen,
  parameter int unsigned init_gap_len = DefInitGapLen,
  parameter int unsigned bursts_num   = DefBurstsNum
) (
  input  logic clk,
  input  logic reset,
  input  logic TXCOMINIT,
  input  logic TXCOMWAKE,
  input  logic TXELECIDLE,
  input  logic txdata,
  output logic TXP,
  output logic TXN,
  output logic TXCOMFINISH,
  output logic oob_busy
);

  if (!in_window(burst_len, BurstWinMin, BurstWinMax) ||
      !in_window(wake_gap_len, BurstWinMin, BurstWinMax)) begin : g_bad_wake_timing
    $error("burst_len/wake_gap_len outside detector window");
  end
  if (!in_window(init_gap_len, InitWinMin, InitWinMax)) begin : g_bad_init_timing
    $error("init_gap_len outside detector window");
  end
  if (bursts_num < SataBurstVal || bursts_num >= 16) begin : g_bad_bursts_num
    $error("bursts_num must be in SataBurstVal..15");
  end

  localparam logic [15:0] BurstLast   = 16'(burst_len - 1);
  localparam logic [15:0] WakeGapLast = 16'(wake_gap_len - 1);
  localparam logic [15:0] InitGapLast = 16'(init_gap_len - 1);
  localparam logic [3:0]  BurstsNum   = 4'(bursts_num);

  oob_state_e  state_q;
  logic [15:0] len_cnt_q;
  logic [3:0]  burst_cnt_q;
  logic        is_init_q;
  logic [15:0] gap_last;
  line_mode_e  line_mode;

  assign gap_last = is_init_q ? InitGapLast : WakeGapLast;

  // The line register adds one cycle, keeping the line aligned with TXCOMFINISH.
  always_comb begin
    line_mode = LineIdle;
    case (state_q)
      StReady: line_mode = TXELECIDLE ? LineIdle : LineData;
      StBurst: line_mode = LineBurst;
      default: line_mode = LineIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReady;
      len_cnt_q   <= '0;
      burst_cnt_q <= '0;
      is_init_q   <= 1'b0;
      TXCOMFINISH <= 1'b0;
      oob_busy    <= 1'b0;
    end else begin
      TXCOMFINISH <= 1'b0;
      case (state_q)
        StReady: begin
          oob_busy <= 1'b0;
          if (TXCOMINIT || TXCOMWAKE) begin
            is_init_q   <= TXCOMINIT;
            burst_cnt_q <= '0;
            len_cnt_q   <= '0;
            state_q     <= StBurst;
            oob_busy    <= 1'b1;
          end
        end
        StBurst: begin
          if (len_cnt_q == BurstLast) begin
            len_cnt_q   <= '0;
            burst_cnt_q <= burst_cnt_q + 4'd1;
            state_q     <= StGap;
          end else begin
            len_cnt_q <= len_cnt_q + 16'd1;
          end
        end
        StGap: begin
          if (len_cnt_q == gap_last) begin
            len_cnt_q <= '0;
            state_q   <= (burst_cnt_q == BurstsNum) ? StFinish : StBurst;
          end else begin
            len_cnt_q <= len_cnt_q + 16'd1;
          end
        end
        StFinish: begin
          TXCOMFINISH <= 1'b1;
          state_q     <= StReady;
        end
        default: state_q <= StReady;
      endcase
    end
  end

  gtxe2_chnl_tx_oob_line u_line (
    .clk    (clk),
    .reset  (reset),
    .mode   (line_mode),
    .txdata (txdata),
    .txp    (TXP),
    .txn    (TXN)
  );

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
// Self-checking bench for gtxe2_chnl_tx_oob with default timing parameters.
module tb_gtxe2_chnl_tx_oob;

  localparam int BurstLen = 240;
  localparam int WakeGap  = 240;
  localparam int InitGap  = 720;
  localparam int NBursts  = 6;

  logic clk = 1'b0;
  logic reset, TXCOMINIT, TXCOMWAKE, TXELECIDLE, txdata;
  logic TXP, TXN, TXCOMFINISH, oob_busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic elecidle;
    logic data;
    logic exp_p;
    logic exp_n;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  gtxe2_chnl_tx_oob dut (
    .clk         (clk),
    .reset       (reset),
    .TXCOMINIT   (TXCOMINIT),
    .TXCOMWAKE   (TXCOMWAKE),
    .TXELECIDLE  (TXELECIDLE),
    .txdata      (txdata),
    .TXP         (TXP),
    .TXN         (TXN),
    .TXCOMFINISH (TXCOMFINISH),
    .oob_busy    (oob_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one OOB sequence and checks it cycle by cycle against a burst/gap model.
  task automatic run_seq(input bit init, input bit wake, input int inject_k, input bit hold,
                         input string tag);
    int   period;
    int   pos;
    int   line_err = 0;
    int   busy_err = 0;
    int   fin_err  = 0;
    logic ep, en;
    period     = BurstLen + (init ? InitGap : WakeGap);
    TXELECIDLE = 1'b0;
    TXCOMINIT  = init;
    TXCOMWAKE  = wake;
    tick;
    check({tag, "_busy_start"}, 32'(oob_busy), 32'd1);
    if (!hold) begin
      TXCOMINIT = 1'b0;
      TXCOMWAKE = 1'b0;
    end
    for (int k = 0; k < NBursts * period; k++) begin
      txdata = 1'($urandom_range(0, 1));
      if (inject_k >= 0) TXCOMWAKE = (k >= inject_k) && (k < inject_k + 3);
      tick;
      pos = k % period;
      ep  = (pos < BurstLen) ? ((pos % 2) == 0) : 1'b0;
      en  = (pos < BurstLen) ? ~ep : 1'b0;
      if (TXP !== ep || TXN !== en) line_err++;
      if (oob_busy !== 1'b1) busy_err++;
      if (TXCOMFINISH !== 1'b0) fin_err++;
    end
    check({tag, "_line_errors"}, 32'(line_err), 32'd0);
    check({tag, "_busy_drops"}, 32'(busy_err), 32'd0);
    check({tag, "_early_finish"}, 32'(fin_err), 32'd0);
    tick;
    check({tag, "_finish_pulse"}, 32'(TXCOMFINISH), 32'd1);
    check({tag, "_busy_at_finish"}, 32'(oob_busy), 32'd1);
    check({tag, "_idle_at_finish"}, {30'd0, TXP, TXN}, 32'd0);
    tick;
    check({tag, "_finish_single"}, 32'(TXCOMFINISH), 32'd0);
    check({tag, "_busy_after"}, 32'(oob_busy), hold ? 32'd1 : 32'd0);
    if (hold) begin
      tick;
      check({tag, "_restart_burst"}, {30'd0, TXP, TXN}, 32'd2);
      TXCOMINIT = 1'b0;
      TXCOMWAKE = 1'b0;
      reset     = 1'b1;
      tick;
      reset = 1'b0;
    end
    TXELECIDLE = 1'b1;
    tick;
  endtask

  initial begin
    int fin_cnt;
    int busy_cnt;
    int line_cnt;
    vecs[0] = '{elecidle: 1'b1, data: 1'b0, exp_p: 1'b0, exp_n: 1'b0};
    vecs[1] = '{elecidle: 1'b1, data: 1'b1, exp_p: 1'b0, exp_n: 1'b0};
    vecs[2] = '{elecidle: 1'b0, data: 1'b1, exp_p: 1'b1, exp_n: 1'b0};
    vecs[3] = '{elecidle: 1'b0, data: 1'b0, exp_p: 1'b0, exp_n: 1'b1};
    vecs[4] = '{elecidle: 1'b0, data: 1'b1, exp_p: 1'b1, exp_n: 1'b0};
    vecs[5] = '{elecidle: 1'b1, data: 1'b1, exp_p: 1'b0, exp_n: 1'b0};

    reset      = 1'b1;
    TXCOMINIT  = 1'b0;
    TXCOMWAKE  = 1'b0;
    TXELECIDLE = 1'b1;
    txdata     = 1'b0;
    tick;
    tick;
    check("reset_txp", 32'(TXP), 32'd0);
    check("reset_txn", 32'(TXN), 32'd0);
    check("reset_finish", 32'(TXCOMFINISH), 32'd0);
    check("reset_busy", 32'(oob_busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      TXELECIDLE = vecs[i].elecidle;
      txdata     = vecs[i].data;
      tick;
      check($sformatf("ready_vec%0d_txp", i), 32'(TXP), 32'(vecs[i].exp_p));
      check($sformatf("ready_vec%0d_txn", i), 32'(TXN), 32'(vecs[i].exp_n));
      check($sformatf("ready_vec%0d_busy", i), 32'(oob_busy), 32'd0);
    end

    run_seq(1'b0, 1'b1, -1, 1'b0, "wake");
    run_seq(1'b1, 1'b0, -1, 1'b0, "init");
    run_seq(1'b1, 1'b1, -1, 1'b0, "both");
    run_seq(1'b0, 1'b1, 2 * (BurstLen + WakeGap) + 100, 1'b0, "wake_inject");
    run_seq(1'b0, 1'b1, -1, 1'b1, "hold");

    // Abort a COMWAKE in the middle of burst 2.
    TXELECIDLE = 1'b0;
    TXCOMWAKE  = 1'b1;
    tick;
    TXCOMWAKE = 1'b0;
    repeat (BurstLen + WakeGap + 50) tick;
    check("abort_pre_busy", 32'(oob_busy), 32'd1);
    reset = 1'b1;
    tick;
    check("abort_line", {30'd0, TXP, TXN}, 32'd0);
    check("abort_busy", 32'(oob_busy), 32'd0);
    check("abort_finish", 32'(TXCOMFINISH), 32'd0);
    reset      = 1'b0;
    TXELECIDLE = 1'b1;
    fin_cnt    = 0;
    busy_cnt   = 0;
    line_cnt   = 0;
    for (int k = 0; k < NBursts * (BurstLen + WakeGap) + 20; k++) begin
      tick;
      if (TXCOMFINISH !== 1'b0) fin_cnt++;
      if (oob_busy !== 1'b0) busy_cnt++;
      if (TXP !== 1'b0 || TXN !== 1'b0) line_cnt++;
    end
    check("abort_no_finish", 32'(fin_cnt), 32'd0);
    check("abort_stays_ready", 32'(busy_cnt), 32'd0);
    check("abort_stays_idle", 32'(line_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_tx_oob.md
Name: gtxe2_chnl_tx_oob

Overview:
- OOB signal generator for the GTXE2 channel transmit side; the link-partner counterpart that feeds the channel RX OOB detector.
- On a TXCOMINIT/TXCOMWAKE request it emits a fixed number of non-idle bursts separated by electrical-idle gaps on TXP/TXN, then pulses TXCOMFINISH.
- Otherwise it passes serialized data through, or holds electrical idle when TXELECIDLE is set.
- Sits between the serializer output and the channel TXP/TXN pins.

Parameters:
- burst_len, 240: cycles of each burst; must lie inside the detector window 150..340.
- wake_gap_len, 240: idle cycles between COMWAKE bursts; must lie inside 150..340.
- init_gap_len, 720: idle cycles between COMINIT bursts; must lie inside 450..990.
- bursts_num, 6: bursts per sequence; must be at least the receiver's SATA_BURST_VAL (4).

Ports:
- clk  in  1  serial-rate clock.
- reset  in  1  synchronous, active-high.
- TXCOMINIT  in  1  request a COMINIT sequence (level, sampled when ready).
- TXCOMWAKE  in  1  request a COMWAKE sequence.
- TXELECIDLE  in  1  force line idle when no sequence is running.
- txdata  in  1  serial data bit from the serializer.
- TXP  out  1  positive line.
- TXN  out  1  negative line.
- TXCOMFINISH  out  1  one-cycle pulse when a sequence completes.
- oob_busy  out  1  high while a sequence runs.

Behaviour:
- Single clock domain: clk with synchronous active-high reset. All outputs are registered.
- Reset values: TXP=0, TXN=0 (line idle), TXCOMFINISH=0, oob_busy=0, state READY, counters 0, is_init=0.
- Line encoding:
  - Idle: TXP=TXN=0.
  - Burst: TXP toggles every cycle starting at 1; TXN=~TXP.
  - Data: TXP=txdata, TXN=~txdata.
- State READY:
  - Output is idle if TXELECIDLE=1, else data.
  - If TXCOMINIT or TXCOMWAKE is high: latch is_init=TXCOMINIT (INIT wins when both are high), burst_cnt=0, len_cnt=0, go to BURST, oob_busy=1.
  - Latency: request sampled at edge N; first burst value appears on TXP/TXN after edge N+1.
- State BURST:
  - Drive the burst pattern; len_cnt increments.
  - When len_cnt==burst_len-1: len_cnt=0, burst_cnt+1, go to GAP.
  - Each burst lasts exactly burst_len cycles.
- State GAP:
  - Drive idle; len_cnt increments.
  - Gap limit is init_gap_len if is_init, else wake_gap_len.
  - On reaching limit-1: len_cnt=0. If burst_cnt==bursts_num go to FINISH, else go to BURST.
  - A trailing gap always follows the last burst.
- State FINISH:
  - TXCOMFINISH=1 for exactly one cycle; line idle; oob_busy drops on the next cycle.
  - Return to READY.
- Requests while busy are ignored; no queuing.
- A request held high through FINISH starts a new sequence on the first READY cycle.
- TXELECIDLE is ignored while busy; the OOB pattern overrides it.
- Reset mid-sequence: on the next edge the line goes idle, TXCOMFINISH is not pulsed, and the block returns to READY.
- Widths: len_cnt is 16 bits; burst_cnt is 4 bits. The elaboration check requires every length < 65536 and bursts_num < 16. No wrap-around occurs within legal parameters.

Decomposition:
- Shared package gtxe2_oob_pkg holds:
  - state encoding (READY, BURST, GAP, FINISH);
  - default burst/gap lengths;
  - detector window constants 150/340/450/990, shared with the RX detector so both ends stay consistent.
- One natural sub-module: gtxe2_chnl_tx_oob_line. It is the registered line encoder: mode (idle/burst/data) plus txdata in, TXP/TXN out, and owns the toggle flop.

Test Plan:
- COMWAKE, default parameters, request at cycle 10:
  - 6 bursts of 240 non-idle cycles with 240-cycle idle gaps, plus a trailing 240-cycle gap.
  - TXCOMFINISH is a single pulse at cycle 10+1+6*480.
  - oob_busy is high across the whole sequence.
- COMINIT: same as COMWAKE but with 720-cycle gaps; TXCOMFINISH occurs 6*960 cycles after the first burst.
- TXCOMINIT and TXCOMWAKE asserted on the same cycle -> INIT gap lengths are used.
- TXCOMWAKE pulsed again during burst 3 -> ignored; exactly 6 bursts and one TXCOMFINISH.
- reset asserted in the middle of burst 2 -> TXP=TXN=0 the next cycle, no TXCOMFINISH, oob_busy=0.
- Loopback into gtxe2_chnl_rx_oob (matching clk):
  - COMINIT -> RXCOMINITDET asserts and RXCOMWAKEDET never asserts.
  - COMWAKE -> RXCOMWAKEDET asserts.
  - TXELECIDLE=0 in READY with txdata toggling -> RXELECIDLE=0.
